fifo_rr_reader: RTL and testbench

//  Drain side of the crossbar's per-source FIFOs. Watches NSRC FIFO read ports, picks a non-empty

---
 rtl/crossbar_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/fifo_rr_reader.sv | 96 +++++++++
 tb/tb_fifo_rr_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared types and constants for the crossbar FIFO drain logic.
//   rd_state_t     : reader FSM state encoding
//   DWIDTH_DEFAULT : default data word width of the per-source FIFOs
package crossbar_pkg;

  localparam int unsigned DWIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_SETTLE = 2'd1,
    RD_OUT    = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   last    : index of the most recent grant; the search starts at last+1
//   gnt_idx : index of the winning requester (0 when any_req is low)
//   any_req : at least one request bit is set
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] gnt_idx,
  output logic           any_req
);

  // Walk last+1, last+2, ... modulo N; the modulo keeps non-power-of-two
  // sizes from ever landing on an index >= N.
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      int unsigned k;
      k = (32'(last) + i) % N;
      if (!any_req && req[IDW'(k)]) begin
        any_req = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_reader.sv
// Drains NSRC per-source FIFOs round-robin onto one valid/ready stream.
//   aclk, areset  : clock, synchronous active-high reset
//   src_not_empty : per-source FIFO not_empty
//   src_data      : per-source registered head word, source k at [k*DWIDTH +: DWIDTH]
//   src_pop       : per-source pop pulse (combinational from state, at most one bit)
//   m_tdata/m_tid : output word and its source index
//   m_tvalid      : output valid, m_tready : downstream ready
module fifo_rr_reader
  import crossbar_pkg::*;
#(
  parameter  int unsigned DWIDTH = DWIDTH_DEFAULT,
  parameter  int unsigned NSRC   = 4,
  localparam int unsigned IDW    = $clog2(NSRC)
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NSRC-1:0]        src_not_empty,
  input  logic [NSRC*DWIDTH-1:0] src_data,
  output logic [NSRC-1:0]        src_pop,
  output logic [DWIDTH-1:0]      m_tdata,
  output logic [IDW-1:0]         m_tid,
  output logic                   m_tvalid,
  input  logic                   m_tready
);

  rd_state_t            state;
  logic [IDW-1:0]       sel;
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       gnt_idx;
  logic                 any_req;
  logic [DWIDTH-1:0]    src_words [NSRC];
  logic [DWIDTH-1:0]    head_word;

  rr_arbiter #(
    .N   (NSRC),
    .IDW (IDW)
  ) u_arb (
    .req     (src_not_empty),
    .last    (last_grant),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // Unpack the flat head-word bus into per-source words.
  for (genvar g = 0; g < NSRC; g++) begin : g_words
    assign src_words[g] = src_data[g*DWIDTH +: DWIDTH];
  end

  assign head_word = src_words[sel];

  // Pop during SETTLE; the FIFO's head word for sel is still the old one
  // this cycle and is captured at the end of it.
  always_comb begin
    src_pop = '0;
    if (state == RD_SETTLE) src_pop[sel] = 1'b1;
  end

  // Reader FSM with registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= RD_IDLE;
      sel        <= '0;
      last_grant <= IDW'(NSRC - 1);
      m_tdata    <= '0;
      m_tid      <= '0;
      m_tvalid   <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (any_req) begin
            sel        <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= RD_SETTLE;
          end
        end
        RD_SETTLE: begin
          m_tdata  <= head_word;
          m_tid    <= sel;
          m_tvalid <= 1'b1;
          state    <= RD_OUT;
        end
        RD_OUT: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            state    <= RD_IDLE;
          end
        end
        default: begin
          m_tvalid <= 1'b0;
          state    <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_reader.sv
// Directed bench for fifo_rr_reader with four FIFO models and a per-source scoreboard.
module tb_fifo_rr_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;

  logic             aclk;
  logic             areset;
  logic [NS-1:0]    src_not_empty;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_pop;
  logic [DW-1:0]    m_tdata;
  logic [1:0]       m_tid;
  logic             m_tvalid;
  logic             m_tready;

  fifo_rr_reader #(.DWIDTH(DW), .NSRC(NS)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .src_not_empty (src_not_empty),
    .src_data      (src_data),
    .src_pop       (src_pop),
    .m_tdata       (m_tdata),
    .m_tid         (m_tid),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int pop_count = 0;
  int accept_count = 0;

  logic [DW-1:0] q     [NS][$];
  logic [DW-1:0] exp_q [NS][$];
  logic [DW-1:0] head_r [NS];
  logic [NS-1:0] ne_r;
  logic [1:0]    log_tid [$];
  logic [DW-1:0] log_data [$];

  // FIFO read ports: not_empty and head word registered from the model queue.
  always @(posedge aclk) begin
    for (int k = 0; k < NS; k++) begin
      ne_r[k]   <= (q[k].size() > 0);
      head_r[k] <= (q[k].size() > 0) ? q[k][0] : 32'h0;
    end
  end

  always_comb begin
    src_not_empty = ne_r;
    for (int k = 0; k < NS; k++) src_data[k*DW +: DW] = head_r[k];
  end

  // Mid-cycle monitor: apply pops, check pop legality, score accepted words.
  always @(negedge aclk) begin
    checks++;
    assert ($countones(src_pop) <= 1) else begin
      failures++;
      $error("FAIL pop_onehot observed=%b expected=at_most_one_bit", src_pop);
    end
    for (int k = 0; k < NS; k++) begin
      if (src_pop[k] === 1'b1) begin
        pop_count++;
        checks++;
        assert (q[k].size() > 0) else begin
          failures++;
          $error("FAIL pop_empty src=%0d observed=empty expected=non_empty", k);
        end
        if (q[k].size() > 0) void'(q[k].pop_front());
      end
    end
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      accept_count++;
      log_tid.push_back(m_tid);
      log_data.push_back(m_tdata);
      checks++;
      assert (exp_q[m_tid].size() > 0 && m_tdata === exp_q[m_tid][0]) else begin
        failures++;
        $error("FAIL sb_order src=%0d observed=%h expected=%h", m_tid, m_tdata,
               (exp_q[m_tid].size() > 0) ? exp_q[m_tid][0] : 32'hx);
      end
      if (exp_q[m_tid].size() > 0) void'(exp_q[m_tid].pop_front());
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input int k, input logic [DW-1:0] w);
    q[k].push_back(w);
    exp_q[k].push_back(w);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_tid.size() < n && c < budget) begin
      step();
      c++;
    end
    checks++;
    assert (log_tid.size() >= n) else begin
      failures++;
      $error("FAIL timeout_log observed=%0d expected=%0d", log_tid.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (m_tvalid !== 1'b1 && c < budget) begin
      step();
      c++;
    end
    check("timeout_valid", 32'(m_tvalid), 32'd1);
  endtask

  task automatic wait_pop(input int budget);
    int c = 0;
    while (src_pop === 4'b0000 && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic [1:0] tid,
                           input logic [DW-1:0] data);
    if (idx < log_tid.size()) begin
      check({tag, "_tid"}, 32'(log_tid[idx]), 32'(tid));
      check({tag, "_data"}, log_data[idx], data);
    end else begin
      check({tag, "_missing"}, 32'(log_tid.size()), 32'(idx + 1));
    end
  endtask

  int base;
  logic [DW-1:0] held_data;

  initial begin
    areset   = 1'b1;
    m_tready = 1'b1;

    // 1: reset held with all sources non-empty
    for (int k = 0; k < NS; k++) push(k, 32'h1000_0000 + 32'(k));
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid", 32'(m_tvalid), 32'd0);
      check("rst_pop", 32'(src_pop), 32'd0);
    end
    check("rst_data", m_tdata, 32'h0);
    check("rst_tid", 32'(m_tid), 32'd0);
    areset = 1'b0;
    wait_pop(10);
    check("first_pop", 32'(src_pop), 32'b0001);
    wait_log(4, 40);
    for (int i = 0; i < 4; i++) check_log("rst_drain", i, 2'(i), 32'h1000_0000 + 32'(i));
    repeat (3) step();

    // 2: single word latency
    push(0, 32'hDEAD_BEEF);
    step();
    check("sw_pop_c", 32'(src_pop), 32'd0);
    step();
    check("sw_pop_c1", 32'(src_pop), 32'b0001);
    check("sw_valid_c1", 32'(m_tvalid), 32'd0);
    step();
    check("sw_valid_c2", 32'(m_tvalid), 32'd1);
    check("sw_data", m_tdata, 32'hDEAD_BEEF);
    check("sw_tid", 32'(m_tid), 32'd0);
    check("sw_pop_c2", 32'(src_pop), 32'd0);
    step();
    check("sw_valid_c3", 32'(m_tvalid), 32'd0);
    check("sw_pop_c3", 32'(src_pop), 32'd0);
    repeat (2) step();

    // 3: round-robin over four preloaded FIFOs, after a reset to restore priority
    areset = 1'b1;
    step();
    areset = 1'b0;
    base = log_tid.size();
    for (int k = 0; k < NS; k++)
      for (int n = 0; n < 3; n++) push(k, 32'hA000_0000 | (32'(k) << 8) | 32'(n));
    wait_log(base + 12, 100);
    for (int i = 0; i < 12; i++)
      check_log("rr", base + i, 2'(i % 4), 32'hA000_0000 | (32'(i % 4) << 8) | 32'(i / 4));
    repeat (3) step();

    // 4: backpressure for 20 cycles in OUT
    m_tready = 1'b0;
    push(0, 32'h4444_0000);
    push(0, 32'h4444_0001);
    push(2, 32'h5555_2222);
    wait_valid(10);
    check("bp_tid", 32'(m_tid), 32'd0);
    check("bp_data", m_tdata, 32'h4444_0000);
    base = pop_count;
    held_data = m_tdata;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_hold_valid", 32'(m_tvalid), 32'd1);
      check("bp_hold_data", m_tdata, held_data);
      check("bp_hold_tid", 32'(m_tid), 32'd0);
    end
    check("bp_no_pops", 32'(pop_count), 32'(base));
    base = log_tid.size();
    m_tready = 1'b1;
    wait_log(base + 3, 30);
    check_log("bp_drain0", base, 2'd0, 32'h4444_0000);
    check_log("bp_drain1", base + 1, 2'd2, 32'h5555_2222);
    check_log("bp_drain2", base + 2, 2'd0, 32'h4444_0001);
    repeat (3) step();

    // 5: sparse sources with the wrap starting from last_grant=3
    base = log_tid.size();
    push(3, 32'h3333_0005);
    wait_log(base + 1, 20);
    check_log("wrap_prime", base, 2'd3, 32'h3333_0005);
    repeat (3) step();
    base = log_tid.size();
    push(3, 32'h3333_0055);
    push(1, 32'h1111_0055);
    wait_log(base + 2, 30);
    check_log("wrap_first", base, 2'd1, 32'h1111_0055);
    check_log("wrap_second", base + 1, 2'd3, 32'h3333_0055);
    repeat (3) step();

    // 6: reset while holding a src2 word
    m_tready = 1'b0;
    push(2, 32'h2222_6666);
    wait_valid(10);
    check("mid_tid", 32'(m_tid), 32'd2);
    push(0, 32'h0A0A_0A0A);
    step();
    areset = 1'b1;
    step();
    check("mid_rst_valid", 32'(m_tvalid), 32'd0);
    check("mid_rst_tid", 32'(m_tid), 32'd0);
    check("mid_rst_data", m_tdata, 32'h0);
    areset = 1'b0;
    void'(exp_q[2].pop_front());
    m_tready = 1'b1;
    base = log_tid.size();
    wait_log(base + 1, 20);
    check_log("mid_next", base, 2'd0, 32'h0A0A_0A0A);
    repeat (8) step();
    check("mid_no_reemit", 32'(log_tid.size()), 32'(base + 1));

    // One pop per emitted word, plus the single word dropped by reset
    check("pop_vs_words", 32'(pop_count), 32'(accept_count + 1));
    for (int k = 0; k < NS; k++) check("fifo_empty", 32'(q[k].size() + exp_q[k].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
